// File: rtl/result_buffer_ctrl.sv
// result_buffer_ctrl: captures the 56-bit result stream into a DEPTH-word RAM.
// It tracks the word count, a modulo-2^DATA_W checksum and a sticky overflow flag,
// and it offers a registered random-access read port.
module result_buffer_ctrl #(
    parameter int DATA_W = 56,
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   wr_count,
    output logic [DATA_W-1:0] checksum,
    output logic              overflow
);

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE} state_t;

    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_en;

    // start has priority, so a word that arrives with start is never stored.
    assign wr_en = (state == S_CAPTURE) && in_valid && !start;

    // Control FSM. Counters and flags are registered alongside the state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            wr_count <= '0;
            checksum <= '0;
            overflow <= 1'b0;
        end else if (start) begin
            state    <= S_CAPTURE;
            busy     <= 1'b1;
            done     <= 1'b0;
            wr_count <= '0;
            checksum <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                S_CAPTURE: begin
                    if (in_valid) begin
                        wr_count <= wr_count + 1'b1;
                        checksum <= checksum + in_data;
                        // This write fills the buffer, so stop here instead of wrapping.
                        if (wr_count == LAST_IDX) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                S_IDLE, S_DONE: begin
                    if (in_valid) overflow <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Result RAM write port. The RAM has no reset, so its contents survive reset and start.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_count[ADDR_W-1:0]] <= in_data;
    end

    // Registered read port. A read of an address written in the same cycle returns the old word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_result_buffer_ctrl.sv
// Directed + randomized bench for result_buffer_ctrl against a behavioural model.
module tb_result_buffer_ctrl;

    localparam int DATA_W = 56;
    localparam int DEPTH  = 512;
    localparam int ADDR_W = 9;

    logic              clk = 1'b0;
    logic              rstn;
    logic              start;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   wr_count;
    logic [DATA_W-1:0] checksum;
    logic              overflow;

    int tests = 0;
    int fails = 0;

    // Reference model: stored words, and which addresses hold a known word.
    logic [DATA_W-1:0] m_mem [DEPTH];
    bit                m_known [DEPTH];
    int                m_cnt;
    logic [DATA_W-1:0] m_sum;
    bit                m_ovf, m_run, m_fin;
    logic [DATA_W-1:0] m_rd;
    bit                m_rdk, m_rv;

    result_buffer_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rstn(rstn), .start(start), .in_data(in_data), .in_valid(in_valid),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .busy(busy), .done(done), .wr_count(wr_count), .checksum(checksum),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_sum = '0; m_ovf = 0; m_run = 0; m_fin = 0;
        m_rd = '0; m_rdk = 1; m_rv = 0;
        for (int i = 0; i < DEPTH; i++) m_known[i] = 0;
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".busy"},     64'(busy),     64'(m_run));
        chk({tag, ".done"},     64'(done),     64'(m_fin));
        chk({tag, ".wr_count"}, 64'(wr_count), 64'(m_cnt));
        chk({tag, ".checksum"}, 64'(checksum), 64'(m_sum));
        chk({tag, ".overflow"}, 64'(overflow), 64'(m_ovf));
        chk({tag, ".rd_valid"}, 64'(rd_valid), 64'(m_rv));
        if (m_rdk) chk({tag, ".rd_data"}, 64'(rd_data), 64'(m_rd));
    endtask

    // One clock: drive at the falling edge, update the model at the rising edge,
    // and check at the next falling edge.
    task automatic cyc(input string tag, input bit s, input bit v, input logic [DATA_W-1:0] d,
                       input bit re, input logic [ADDR_W-1:0] ra);
        start = s; in_valid = v; in_data = d; rd_en = re; rd_addr = ra;
        @(posedge clk);
        m_rv = re;
        if (re) begin
            m_rd  = m_mem[int'(ra)];
            m_rdk = m_known[int'(ra)];
        end
        if (s) begin
            m_run = 1; m_fin = 0; m_cnt = 0; m_sum = '0; m_ovf = 0;
        end else if (v) begin
            if (m_run) begin
                m_mem[m_cnt] = d;
                m_known[m_cnt] = 1;
                m_cnt++;
                m_sum = m_sum + d;
                if (m_cnt == DEPTH) begin
                    m_run = 0; m_fin = 1;
                end
            end else begin
                m_ovf = 1;
            end
        end
        @(negedge clk);
        chk_all(tag);
    endtask

    function automatic logic [DATA_W-1:0] rnd56();
        return DATA_W'({$urandom, $urandom});
    endfunction

    initial begin
        model_reset();
        rstn = 1'b0; start = 0; in_valid = 0; in_data = '0; rd_en = 0; rd_addr = '0;
        repeat (2) @(negedge clk);
        chk_all("reset");
        rstn = 1'b1;

        // A word in IDLE is dropped and sets overflow.
        cyc("idle_ovf", 0, 1, 56'hAA, 0, '0);
        chk("idle_ovf_flag", 64'(overflow), 64'd1);

        // A full back-to-back run of i*3.
        cyc("start1", 1, 0, '0, 0, '0);
        chk("start1_ovf_clr", 64'(overflow), 64'd0);
        for (int i = 0; i < DEPTH; i++) cyc("run3", 0, 1, DATA_W'(i * 3), 0, '0);
        chk("full_done", 64'(done), 64'd1);
        chk("full_cnt", 64'(wr_count), 64'd512);
        chk("full_sum", 64'(checksum), 64'h5FD00);

        // A word after DONE sets overflow and leaves the count unchanged.
        cyc("done_ovf", 0, 1, 56'hAA, 0, '0);
        chk("done_ovf_cnt", 64'(wr_count), 64'd512);

        // Read all addresses back; then one idle cycle, where rd_data must hold.
        for (int i = 0; i < DEPTH; i++) cyc("read3", 0, 0, '0, 1, ADDR_W'(i));
        chk("read_last", 64'(rd_data), 64'(511 * 3));
        cyc("read_hold", 0, 0, '0, 0, '0);

        // start with a word in the same cycle: the word is ignored.
        cyc("start_v", 1, 1, 56'h77, 0, '0);
        chk("start_v_ovf", 64'(overflow), 64'd0);
        cyc("start_v_rd", 0, 0, '0, 1, '0);
        cyc("start_v_rd2", 0, 0, '0, 0, '0);
        chk("start_v_addr0", 64'(rd_data), 64'd0);

        // Checksum wrap.
        cyc("wrap_st", 1, 0, '0, 0, '0);
        cyc("wrap_a", 0, 1, 56'h00FF_FFFF_FFFF_FFFF, 0, '0);
        cyc("wrap_b", 0, 1, 56'h1, 0, '0);
        chk("wrap_sum", 64'(checksum), 64'd0);
        chk("wrap_cnt", 64'(wr_count), 64'd2);
        chk("wrap_busy", 64'(busy), 64'd1);

        // Restart after 100 words; the next word lands at address 0.
        cyc("mid_st", 1, 0, '0, 0, '0);
        for (int i = 0; i < 100; i++) cyc("mid_w", 0, 1, rnd56(), 0, '0);
        cyc("mid_restart", 1, 0, '0, 0, '0);
        chk("mid_cnt", 64'(wr_count), 64'd0);
        chk("mid_sum", 64'(checksum), 64'd0);
        cyc("mid_w1234", 0, 1, 56'h1234, 0, '0);
        cyc("mid_rd", 0, 0, '0, 1, '0);
        chk("mid_rd0", 64'(rd_data), 64'h1234);

        // Same-cycle read and write of address 5: the read returns the old word.
        cyc("rbw_st", 1, 0, '0, 0, '0);
        for (int i = 0; i < 5; i++) cyc("rbw_w", 0, 1, rnd56(), 0, '0);
        cyc("rbw_55", 0, 1, 56'h55, 0, '0);
        cyc("rbw_st2", 1, 0, '0, 0, '0);
        for (int i = 0; i < 5; i++) cyc("rbw_w2", 0, 1, rnd56(), 0, '0);
        cyc("rbw_66", 0, 1, 56'h66, 1, 9'd5);
        chk("rbw_old", 64'(rd_data), 64'h55);
        cyc("rbw_new", 0, 0, '0, 1, 9'd5);
        chk("rbw_new_val", 64'(rd_data), 64'h66);

        // Sparse run (about one word per 4 cycles) to completion, with random reads.
        cyc("sp_st", 1, 0, '0, 0, '0);
        for (int i = 0; i < 2600; i++)
            cyc("sparse", 0, ($urandom_range(3) == 0), rnd56(),
                $urandom_range(1) == 1, ADDR_W'($urandom));
        chk("sparse_done", 64'(done), 64'd1);

        // Random mix, including occasional restarts.
        for (int i = 0; i < 1500; i++)
            cyc("rand", $urandom_range(99) == 0, $urandom_range(1) == 1, rnd56(),
                $urandom_range(1) == 1, ADDR_W'($urandom));

        // Asynchronous reset in the middle of a capture.
        cyc("ar_st", 1, 0, '0, 0, '0);
        for (int i = 0; i < 10; i++) cyc("ar_w", 0, 1, rnd56(), 1, ADDR_W'(i));
        start = 0; in_valid = 0; rd_en = 0;
        #2 rstn = 1'b0;
        #1 model_reset();
        chk_all("async_rst");
        @(negedge clk);
        rstn = 1'b1;
        cyc("post_rst", 0, 0, '0, 0, '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/result_buffer_ctrl.md
# result_buffer_ctrl

Downstream capture stage for the matrix memory controller. Accepts the 56-bit result stream one word per valid strobe and stores up to 512 words in an internal result RAM. Keeps a running word count and a modulo-2^56 checksum, and offers a registered random-access read port so a host or bench can drain or compare results after the run completes.

## Interface
Parameters:
- DATA_W, 56, result word width
- DEPTH, 512, number of result words per run
- ADDR_W, 9, address width (log2 DEPTH)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rstn  input  1  asynchronous active-low reset
- start  input  1  single-cycle pulse: clear count/checksum/overflow, enter CAPTURE
- in_data  input  DATA_W  result word from the memory controller
- in_valid  input  1  in_data is valid this cycle
- rd_en  input  1  read request
- rd_addr  input  ADDR_W  read address
- rd_data  output  DATA_W  registered read data
- rd_valid  output  1  rd_data valid (rd_en delayed by one cycle)
- busy  output  1  high in CAPTURE
- done  output  1  high in DONE
- wr_count  output  ADDR_W+1  words captured this run, 0..DEPTH
- checksum  output  DATA_W  sum of captured words mod 2^DATA_W
- overflow  output  1  sticky: in_valid seen outside CAPTURE

One clock; reset is asynchronous and active-low (ports clk and rstn).

## Operation
- States: IDLE, CAPTURE, DONE. Encoding is free.
- IDLE: start goes to CAPTURE. in_valid is dropped and sets overflow.
- CAPTURE: each in_valid writes in_data to RAM[wr_count[ADDR_W-1:0]], then wr_count+1 and checksum+in_data (carry out discarded).
- When the write that makes wr_count equal DEPTH occurs, the next state is DONE. No wrap-around, and no address 0 rewrite.
- DONE: in_valid is dropped and sets overflow. start returns to CAPTURE with clears.
- start in any state, including mid-CAPTURE: the next cycle shows wr_count=0, checksum=0, overflow=0, state CAPTURE.
- in_valid in the same cycle as start is ignored. It is not written and does not set overflow. start has priority.
- RAM contents are not cleared by start or reset. A restarted run overwrites from address 0.
- Read port is independent of state:
  - rd_en at edge n gives rd_data=RAM[rd_addr] and rd_valid=1 after edge n+1.
  - When rd_en=0, rd_data holds its last value and rd_valid=0.
- Read and write to the same address in the same cycle: rd_data returns the old contents (read-before-write).
- rd_addr is always < DEPTH when ADDR_W=9. There is no out-of-range case.

## Timing
- Reset values: state IDLE, busy=0, done=0, wr_count=0, checksum=0, overflow=0, rd_data=0, rd_valid=0.
- busy and done are registered state decodes. Both change one cycle after the triggering edge.
- Capture latency: in_valid sampled at edge n shows in wr_count and checksum after edge n.
  - The word is readable by an rd_en issued at edge n+1 or later.
- done rises at the edge that samples the 512th accepted in_valid. busy falls at the same edge.
- Back-to-back in_valid every cycle is supported: a full run takes 512 cycles.
- Sparse in_valid (for example one per 4 cycles) is equally supported.
- Reset asserted mid-run: all outputs return to reset values immediately (asynchronous). RAM contents are undefined and not relied on.

## Test plan
- Reset then start, followed by 512 in_valid words i·3 (i=0..511) every cycle:
  - done rises after the 512th word; wr_count=512.
  - checksum=392448 (0x5FD00).
  - Reading addresses 0..511 returns i·3 with rd_valid one cycle after rd_en.
- Words 0x00FF_FFFF_FFFF_FFFF and 0x1 captured after start:
  - checksum wraps to 0; wr_count=2; busy=1.
- in_valid with 0xAA in IDLE, then again after done:
  - overflow=1 and wr_count is unchanged.
  - The next start clears overflow to 0.
- start mid-run after 100 words:
  - wr_count=0, checksum=0.
  - The next word 0x1234 lands at address 0 and reads back as 0x1234.
- start and in_valid=1 (data 0x77) in the same cycle:
  - wr_count=0, overflow=0 next cycle, and address 0 is not written.
- Same-cycle rd_en and in_valid to address 5, where it previously held 0x55 and the new word is 0x66:
  - rd_data=0x55.
  - A following read returns 0x66.
- rstn asserted mid-CAPTURE:
  - All outputs go to 0 without waiting for a clock edge; state returns to IDLE.
